// File: rtl/mc_datapath_hs_pkg.sv
// Shared encodings and types for the multicycle datapath.
// ALU/mux select codes, reset PC default, handshake state enum.
package mc_datapath_hs_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_RSV = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;
    localparam logic [1:0] PCSRC_JR   = 2'b11;

    localparam logic [31:0] PC_START_DEF = 32'h0000_0000;

    localparam int XLEN_DEF = 32;
    typedef logic [XLEN_DEF-1:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hs_state_e;

endpackage

// File: rtl/mc_datapath_hs_alu.sv
// XLEN-wide ALU with zero and signed-overflow flags.
// Ports: a, b, alucont in; result, zero, overflow out.
module alu_w
    import mc_datapath_hs_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      alucont,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            overflow
);

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic            ovf_add;
    logic            ovf_sub;
    logic            lt;

    assign sum  = a + b;
    assign diff = a - b;

    assign ovf_add = (a[XLEN-1] == b[XLEN-1]) & (sum[XLEN-1] != a[XLEN-1]);
    assign ovf_sub = (a[XLEN-1] != b[XLEN-1]) & (diff[XLEN-1] != a[XLEN-1]);

    // sign of a-b is wrong exactly when the subtraction overflowed
    assign lt = diff[XLEN-1] ^ ovf_sub;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        unique case (alucont)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: begin
                result   = sum;
                overflow = ovf_add;
            end
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_RSV: result = '0;
            ALU_SUB: begin
                result   = diff;
                overflow = ovf_sub;
            end
            ALU_SLT: result = {{(XLEN-1){1'b0}}, lt};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mc_datapath_hs_regfile.sv
// Register file, two read ports, one write port, r0 hardwired to 0.
// Ports: clk, reset, we, ra1, ra2, wa, wd in; rd1, rd2 out.
module regfile_n #(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    localparam int IW = $clog2(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    // r0 and addresses beyond NREG are not backed by storage
    function automatic logic live(input logic [4:0] ad);
        return (ad != 5'd0) && (32'(ad) < NREG);
    endfunction

    assign rd1 = live(ra1) ? regs_q[ra1[IW-1:0]] : '0;
    assign rd2 = live(ra2) ? regs_q[ra2[IW-1:0]] : '0;

    always_comb begin
        regs_d = regs_q;
        if (we && live(wa)) begin
            regs_d[wa[IW-1:0]] = wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/mc_datapath_hs.sv
// Multicycle datapath with IR/MDR/A/B latches and a req/ack memory port.
// Ports: controller enables/selects in; opcode, funct, flags, stall out; mem_* bus.
module mc_datapath_hs
    import mc_datapath_hs_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter int          NREG     = 32,
    parameter logic [31:0] PC_START = PC_START_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pcen,
    input  logic            irwrite,
    input  logic            regwrite,
    input  logic            iord,
    input  logic            memread,
    input  logic            memwrite,
    input  logic            alusrca,
    input  logic [1:0]      alusrcb,
    input  logic            extop,
    input  logic            regdst,
    input  logic            memtoreg,
    input  logic [1:0]      pcsrc,
    input  logic [2:0]      alucont,
    output logic [5:0]      opcode,
    output logic [5:0]      funct,
    output logic            zero,
    output logic            overflow,
    output logic            stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack
);

    hs_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] mdr_q, mdr_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] aluout_q, aluout_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

    logic            req;
    logic [XLEN-1:0] rd1, rd2;
    logic [XLEN-1:0] imm, src_a, src_b;
    logic [XLEN-1:0] aluresult, jump_tgt;
    logic [4:0]      wa;
    logic [XLEN-1:0] wd;

    assign req   = memread | memwrite;
    assign stall = ((state_q == IDLE) & req) | ((state_q == BUSY) & ~mem_ack);

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];

    assign imm = extop ? {{(XLEN-16){1'b0}}, ir_q[15:0]}
                       : {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
    assign jump_tgt = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};

    assign src_a = alusrca ? a_q : pc_q;

    always_comb begin
        src_b = b_q;
        unique case (alusrcb)
            SRCB_B:    src_b = b_q;
            SRCB_FOUR: src_b = {{(XLEN-3){1'b0}}, 3'd4};
            SRCB_IMM:  src_b = imm;
            SRCB_IMM4: src_b = {imm[XLEN-3:0], 2'b00};
            default:   src_b = b_q;
        endcase
    end

    assign wa = regdst ? ir_q[15:11] : ir_q[20:16];
    assign wd = memtoreg ? mdr_q : aluout_q;

    regfile_n #(.NREG(NREG), .XLEN(XLEN)) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (regwrite & ~stall),
        .ra1   (ir_q[25:21]),
        .ra2   (ir_q[20:16]),
        .wa    (wa),
        .wd    (wd),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    alu_w #(.XLEN(XLEN)) u_alu (
        .a        (src_a),
        .b        (src_b),
        .alucont  (alucont),
        .result   (aluresult),
        .zero     (zero),
        .overflow (overflow)
    );

    always_comb begin
        pc_d     = pc_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        if (!stall) begin
            a_d      = rd1;
            b_d      = rd2;
            aluout_d = aluresult;
            if (pcen) begin
                unique case (pcsrc)
                    PCSRC_ALU:  pc_d = aluresult;
                    PCSRC_OUT:  pc_d = aluout_q;
                    PCSRC_JUMP: pc_d = jump_tgt;
                    PCSRC_JR:   pc_d = a_q;
                    default:    pc_d = pc_q;
                endcase
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ir_d        = ir_q;
        mdr_d       = mdr_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d     = BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = memwrite;
                    mem_addr_d  = iord ? aluout_q : pc_q;
                    mem_wdata_d = b_q;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        if (irwrite) ir_d = mem_rdata[31:0];
                        else         mdr_d = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= XLEN'(PC_START);
            ir_q        <= '0;
            mdr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            aluout_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            mdr_q       <= mdr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            aluout_q    <= aluout_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mc_datapath_hs.sv
// Directed + randomized bench for mc_datapath_hs.
// A second instance with NREG=8 exercises out-of-range register addresses.
module tb_mc_datapath_hs;

    logic        clk;
    logic        reset;
    logic        pcen, irwrite, regwrite, iord;
    logic        memread, memwrite, alusrca;
    logic [1:0]  alusrcb;
    logic        extop, regdst, memtoreg;
    logic [1:0]  pcsrc;
    logic [2:0]  alucont;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic [5:0]  opcode, funct;
    logic        zero, overflow, stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;

    logic [5:0]  opcode_8, funct_8;
    logic        zero_8, overflow_8, stall_8;
    logic        mem_req_8, mem_we_8;
    logic [31:0] mem_addr_8, mem_wdata_8;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc, m_ir, m_mdr;
    logic [31:0] m_regs [32];

    mc_datapath_hs #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .reset(reset), .pcen(pcen), .irwrite(irwrite),
        .regwrite(regwrite), .iord(iord), .memread(memread),
        .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .extop(extop), .regdst(regdst), .memtoreg(memtoreg),
        .pcsrc(pcsrc), .alucont(alucont), .opcode(opcode), .funct(funct),
        .zero(zero), .overflow(overflow), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    mc_datapath_hs #(.XLEN(32), .NREG(8)) dut8 (
        .clk(clk), .reset(reset), .pcen(pcen), .irwrite(irwrite),
        .regwrite(regwrite), .iord(iord), .memread(memread),
        .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .extop(extop), .regdst(regdst), .memtoreg(memtoreg),
        .pcsrc(pcsrc), .alucont(alucont), .opcode(opcode_8),
        .funct(funct_8), .zero(zero_8), .overflow(overflow_8),
        .stall(stall_8), .mem_req(mem_req_8), .mem_we(mem_we_8),
        .mem_addr(mem_addr_8), .mem_wdata(mem_wdata_8),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU: {overflow, result} from plain signed/unsigned arithmetic
    function automatic logic [32:0] alu_ref(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, r;
        longint maxv, minv;
        logic [31:0] res;
        logic ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        maxv = 2147483647;
        minv = -maxv - 1;
        ov = 1'b0;
        res = 32'h0;
        r = 0;
        case (op)
            3'd0: res = a & b;
            3'd1: res = a | b;
            3'd2: begin
                r = sa + sb;
                res = r[31:0];
                ov = (r > maxv) || (r < minv);
            end
            3'd3: res = a ^ b;
            3'd4: res = ~(a | b);
            3'd6: begin
                r = sa - sb;
                res = r[31:0];
                ov = (r > maxv) || (r < minv);
            end
            3'd7: res = (sa < sb) ? 32'd1 : 32'd0;
            default: res = 32'h0;
        endcase
        return {ov, res};
    endfunction

    task automatic mem_access(input logic wr, input logic irw,
                              input logic [31:0] rd, input int waits,
                              input logic [31:0] exp_addr,
                              input logic [31:0] exp_wd, input int creg);
        int st;
        st = 0;
        memread = ~wr;
        memwrite = wr;
        irwrite = irw;
        #1;
        if (stall) st++;
        tick();
        for (int i = 0; i <= waits; i++) begin
            chk("acc_req", mem_req, 1);
            chk("acc_we", mem_we, wr);
            chk("acc_addr", mem_addr, exp_addr);
            chk("acc_pc_hold", dut.pc_q, m_pc);
            if (wr) chk("acc_wdata", mem_wdata, exp_wd);
            if (creg >= 0)
                chk("gate_reg", dut.u_rf.regs_q[creg[4:0]], m_regs[creg[4:0]]);
            if (i == waits) begin
                mem_ack = 1'b1;
                mem_rdata = rd;
            end
            #1;
            if (stall) st++;
            tick();
        end
        mem_ack = 1'b0;
        memread = 1'b0;
        memwrite = 1'b0;
        irwrite = 1'b0;
        if (!wr) begin
            if (irw) m_ir = rd;
            else     m_mdr = rd;
        end
        chk("acc_done", mem_req, 0);
        chk("acc_stall_cycles", st, waits + 1);
        chk("acc_ir", dut.ir_q, m_ir);
        chk("acc_mdr", dut.mdr_q, m_mdr);
    endtask

    task automatic fetch(input logic [31:0] ins, input int waits);
        iord = 1'b0;
        alusrca = 1'b0;
        alusrcb = 2'b01;
        pcsrc = 2'b00;
        alucont = 3'b010;
        pcen = 1'b1;
        mem_access(1'b0, 1'b1, ins, waits, m_pc, 32'h0, -1);
        pcen = 1'b0;
        alusrcb = 2'b00;
        alucont = 3'b000;
        m_pc = m_pc + 32'd4;
        chk("fetch_pc", dut.pc_q, m_pc);
    endtask

    task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
        fetch({6'h00, 5'd0, r, 16'h0000}, 1);
        iord = 1'b0;
        mem_access(1'b0, 1'b0, v, 0, m_pc, 32'h0, -1);
        regwrite = 1'b1;
        memtoreg = 1'b1;
        regdst = 1'b0;
        tick();
        regwrite = 1'b0;
        memtoreg = 1'b0;
        if (r != 5'd0) m_regs[r] = v;
    endtask

    logic [2:0]  d_op [5];
    logic [31:0] d_a  [5];
    logic [31:0] d_b  [5];
    logic [31:0] ra, rb, exp_b, immx, rdv;
    logic [15:0] imm16;
    logic [25:0] tgt;
    logic [2:0]  op;
    logic [1:0]  sel;
    logic        ext;
    logic [32:0] ref_out;

    initial begin
        d_op[0] = 3'b010; d_a[0] = 32'h7FFF_FFFF; d_b[0] = 32'h1;
        d_op[1] = 3'b110; d_a[1] = 32'h8000_0000; d_b[1] = 32'h1;
        d_op[2] = 3'b111; d_a[2] = 32'hFFFF_FFFF; d_b[2] = 32'h1;
        d_op[3] = 3'b101; d_a[3] = 32'h5;         d_b[3] = 32'h6;
        d_op[4] = 3'b110; d_a[4] = 32'h1234_5678; d_b[4] = 32'h1234_5678;

        reset = 1'b1;
        {pcen, irwrite, regwrite, iord, memread, memwrite} = '0;
        {alusrca, extop, regdst, memtoreg} = '0;
        alusrcb = 2'b00;
        pcsrc = 2'b00;
        alucont = 3'b000;
        mem_rdata = 32'h0;
        mem_ack = 1'b0;
        m_pc = 32'h0;
        m_ir = 32'h0;
        m_mdr = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", dut.pc_q, 32'h0);
        chk("rst_ir", dut.ir_q, 32'h0);
        chk("rst_aluout", dut.aluout_q, 32'h0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // instruction fetch, 3 wait cycles, PC+4 at the ack edge
        fetch(32'h8C0A_0004, 3);
        chk("fetch_opcode", opcode, 32'h23);
        chk("fetch_funct", funct, 32'h04);

        // lw r10, 4(r1) with r1 = 0x100
        set_reg(5'd1, 32'h100);
        fetch(32'h8C2A_0004, 1);
        tick();
        chk("lw_a", dut.a_q, 32'h100);
        alusrca = 1'b1;
        alusrcb = 2'b10;
        extop = 1'b0;
        alucont = 3'b010;
        tick();
        chk("lw_aluout", dut.aluout_q, 32'h104);
        iord = 1'b1;
        mem_access(1'b0, 1'b0, 32'hDEAD_BEEF, 2, 32'h104, 32'h0, -1);
        iord = 1'b0;
        alusrca = 1'b0;
        alusrcb = 2'b00;
        alucont = 3'b000;
        regwrite = 1'b1;
        memtoreg = 1'b1;
        regdst = 1'b0;
        tick();
        regwrite = 1'b0;
        memtoreg = 1'b0;
        m_regs[10] = m_mdr;
        chk("lw_r10", dut.u_rf.regs_q[10], 32'hDEAD_BEEF);

        // sw r5 with regwrite held high across the stall
        set_reg(5'd5, 32'h55);
        fetch({6'h2B, 5'd0, 5'd5, 16'h0000}, 1);
        tick();
        chk("sw_b", dut.b_q, 32'h55);
        regwrite = 1'b1;
        memtoreg = 1'b1;
        regdst = 1'b0;
        mem_access(1'b1, 1'b0, $urandom, 5, m_pc, 32'h55, 5);
        regwrite = 1'b0;
        memtoreg = 1'b0;
        m_regs[5] = m_mdr;
        chk("gate_reg_ack", dut.u_rf.regs_q[5], m_regs[5]);

        // ALU: directed corner cases, then random operands/ops/immediates
        for (int k = 0; k < 14; k++) begin
            if (k < 5) begin
                op = d_op[k]; ra = d_a[k]; rb = d_b[k];
                sel = 2'b00; ext = 1'b0; imm16 = 16'h0;
            end else begin
                op = 3'($urandom_range(0, 7));
                ra = $urandom;
                rb = (k == 6) ? ra : $urandom;
                rdv = $urandom_range(0, 2);
                sel = (rdv == 0) ? 2'b00 : (rdv == 1) ? 2'b10 : 2'b11;
                ext = 1'($urandom_range(0, 1));
                imm16 = 16'($urandom);
            end
            set_reg(5'd1, ra);
            set_reg(5'd2, rb);
            fetch({6'h00, 5'd1, 5'd2, imm16}, 0);
            tick();
            immx = ext ? {16'h0, imm16} : {{16{imm16[15]}}, imm16};
            exp_b = (sel == 2'b00) ? m_regs[2]
                  : (sel == 2'b10) ? immx : (immx << 2);
            ref_out = alu_ref(op, m_regs[1], exp_b);
            alusrca = 1'b1;
            alusrcb = sel;
            extop = ext;
            alucont = op;
            #1;
            chk("alu_zero", zero, (ref_out[31:0] == 32'h0));
            chk("alu_ovf", overflow, ref_out[32]);
            tick();
            chk("alu_out", dut.aluout_q, ref_out[31:0]);
            alusrca = 1'b0;
            alusrcb = 2'b00;
            extop = 1'b0;
            alucont = 3'b000;
        end

        // r0 and out-of-range writes are dropped
        set_reg(5'd0, 32'h1234);
        set_reg(5'd9, 32'h1234);
        fetch({6'h00, 5'd0, 5'd9, 16'h0000}, 0);
        tick();
        chk("r0_a", dut.a_q, m_regs[0]);
        chk("r9_b32", dut.b_q, m_regs[9]);
        chk("r0_a8", dut8.a_q, 32'h0);
        chk("r9_b8", dut8.b_q, 32'h0);

        // jr through the A latch
        set_reg(5'd3, 32'h400);
        fetch({6'h00, 5'd3, 5'd0, 16'h0008}, 0);
        tick();
        pcen = 1'b1;
        pcsrc = 2'b11;
        tick();
        pcen = 1'b0;
        pcsrc = 2'b00;
        m_pc = m_regs[3];
        chk("jr_pc", dut.pc_q, 32'h400);

        // j target
        tgt = 26'($urandom);
        fetch({6'h02, tgt}, 0);
        pcen = 1'b1;
        pcsrc = 2'b10;
        tick();
        pcen = 1'b0;
        pcsrc = 2'b00;
        m_pc = {m_pc[31:28], tgt, 2'b00};
        chk("j_pc", dut.pc_q, m_pc);

        // reset in the middle of a fetch
        alusrcb = 2'b01;
        alucont = 3'b010;
        pcen = 1'b1;
        irwrite = 1'b1;
        memread = 1'b1;
        tick();
        chk("mid_req", mem_req, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_pc", dut.pc_q, 32'h0);
        chk("mid_rst_ir", dut.ir_q, 32'h0);
        memread = 1'b0;
        irwrite = 1'b0;
        pcen = 1'b0;
        alusrcb = 2'b00;
        alucont = 3'b000;
        @(negedge clk);
        reset = 1'b0;
        tick();

        // ack while idle is ignored
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        chk("idle_ack_ir", dut.ir_q, 32'h0);
        chk("idle_ack_mdr", dut.mdr_q, 32'h0);
        chk("idle_ack_req", mem_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
